// File: rtl/mem_pkg.sv
// Shared types and parameter defaults for the single-port-storage memory subsystem.
package mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam int DEF_DATA_W  = 64;
  localparam int DEF_INSTR_W = 32;
  localparam int DEF_ADDR_W  = 64;
  localparam int DEF_DEPTH   = 1024;
  localparam int DEF_LATENCY = 1;

  // Ceiling log2 for elaboration-time width calculations.
  function automatic int clog2_f(input int value);
    int result;
    int span;
    result = 32'sd0;
    span   = 32'sd1;
    while (span < value) begin
      span   = span * 32'sd2;
      result = result + 32'sd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Two-way round-robin grant between the instruction and data request ports.
module mem_arbiter (
  input  logic clk,
  input  logic rst,
  input  logic i_req,
  input  logic d_req,
  input  logic accept,
  output logic grant_i,
  output logic grant_d
);

  logic last_d_r;

  // A lone requester wins; on a tie the port not granted last wins.
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (d_req && (!i_req || !last_d_r)) begin
      grant_d = 1'b1;
    end else if (i_req) begin
      grant_i = 1'b1;
    end else begin
      grant_i = 1'b0;
      grant_d = 1'b0;
    end
  end

  // History only moves when a grant turns into an accepted request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_d_r <= 1'b0;
    end else if (accept) begin
      last_d_r <= grant_d;
    end
  end

endmodule

// File: rtl/mem_subsystem.sv
// Shared instruction/data memory: one transaction in flight, fixed accept-to-response latency.
module mem_subsystem import mem_pkg::*; #(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int INSTR_W = DEF_INSTR_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int LATENCY = DEF_LATENCY
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_req_valid,
  output logic                i_req_ready,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_resp_valid,
  input  logic                i_resp_ready,
  output logic [INSTR_W-1:0]  i_instr,
  output logic                i_err,
  input  logic                d_req_valid,
  output logic                d_req_ready,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_be,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_resp_valid,
  input  logic                d_resp_ready,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_err
);

  localparam int BYTES  = DATA_W / 8;
  localparam int OFF_W  = clog2_f(BYTES);
  localparam int IOFF_W = clog2_f(INSTR_W / 8);
  localparam int IDX_W  = clog2_f(DEPTH);
  localparam int CNT_W  = clog2_f(LATENCY) + 1;

  state_e             state_r, state_nx_s;
  logic [CNT_W-1:0]   cnt_r;
  logic [DATA_W-1:0]  mem_r [DEPTH];
  logic               grant_i_s, grant_d_s, accept_s, enter_resp_s;
  logic [ADDR_W-1:0]  acc_addr_s;
  logic               acc_err_s;
  logic               sel_d_r, err_r, we_r;
  logic [IDX_W-1:0]   idx_r;
  logic [OFF_W-1:0]   off_r;
  logic [BYTES-1:0]   be_r;
  logic [DATA_W-1:0]  wdata_r;
  logic               txn_sel_d_s, txn_err_s, txn_we_s;
  logic [IDX_W-1:0]   txn_idx_s;
  logic [OFF_W-1:0]   txn_off_s;
  logic [BYTES-1:0]   txn_be_s;
  logic [DATA_W-1:0]  txn_wdata_s;
  logic [DATA_W-1:0]  rd_word_s;

  mem_arbiter u_arb (
    .clk     (clk),
    .rst     (rst),
    .i_req   (i_req_valid),
    .d_req   (d_req_valid),
    .accept  (accept_s),
    .grant_i (grant_i_s),
    .grant_d (grant_d_s)
  );

  assign accept_s     = i_req_ready | d_req_ready;
  assign acc_addr_s   = grant_d_s ? d_addr : i_addr;
  assign enter_resp_s = (state_r != ST_RESP) && (state_nx_s == ST_RESP);
  assign rd_word_s    = mem_r[txn_idx_s];

  // Misalignment is judged against the requesting port's access size; range by the bits above the array.
  always_comb begin
    if (grant_d_s) begin
      acc_err_s = (|d_addr[OFF_W-1:0]) || (|d_addr[ADDR_W-1:OFF_W+IDX_W]);
    end else begin
      acc_err_s = (|i_addr[IOFF_W-1:0]) || (|i_addr[ADDR_W-1:OFF_W+IDX_W]);
    end
  end

  // With LATENCY=1 the access happens on the accept edge, so IDLE uses the live request.
  always_comb begin
    if (state_r == ST_IDLE) begin
      txn_sel_d_s = grant_d_s;
      txn_err_s   = acc_err_s;
      txn_we_s    = d_we && grant_d_s;
      txn_idx_s   = acc_addr_s[OFF_W +: IDX_W];
      txn_off_s   = acc_addr_s[OFF_W-1:0];
      txn_be_s    = d_be;
      txn_wdata_s = d_wdata;
    end else begin
      txn_sel_d_s = sel_d_r;
      txn_err_s   = err_r;
      txn_we_s    = we_r;
      txn_idx_s   = idx_r;
      txn_off_s   = off_r;
      txn_be_s    = be_r;
      txn_wdata_s = wdata_r;
    end
  end

  // State register and WAIT countdown.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= '0;
    end else begin
      state_r <= state_nx_s;
      if (accept_s) begin
        cnt_r <= CNT_W'(LATENCY - 32'sd1);
      end else if (state_r == ST_WAIT) begin
        cnt_r <= cnt_r - CNT_W'(32'd1);
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) state_nx_s = (LATENCY == 32'sd1) ? ST_RESP : ST_WAIT;
        else          state_nx_s = ST_IDLE;
      end
      ST_WAIT: begin
        if (cnt_r == CNT_W'(32'd1)) state_nx_s = ST_RESP;
        else                        state_nx_s = ST_WAIT;
      end
      ST_RESP: begin
        if (sel_d_r ? d_resp_ready : i_resp_ready) state_nx_s = ST_IDLE;
        else                                       state_nx_s = ST_RESP;
      end
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded from the registered state.
  always_comb begin
    i_req_ready  = 1'b0;
    d_req_ready  = 1'b0;
    i_resp_valid = 1'b0;
    d_resp_valid = 1'b0;
    case (state_r)
      ST_IDLE: begin
        i_req_ready = !rst && grant_i_s;
        d_req_ready = !rst && grant_d_s;
      end
      ST_RESP: begin
        i_resp_valid = !sel_d_r;
        d_resp_valid = sel_d_r;
      end
      ST_WAIT: begin
        i_resp_valid = 1'b0;
        d_resp_valid = 1'b0;
      end
      default: begin
        i_resp_valid = 1'b0;
        d_resp_valid = 1'b0;
      end
    endcase
  end

  // Latch the accepted request; load only the selected port's response on entry to RESP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_d_r <= 1'b0;
      err_r   <= 1'b0;
      we_r    <= 1'b0;
      idx_r   <= '0;
      off_r   <= '0;
      be_r    <= '0;
      wdata_r <= '0;
      i_instr <= '0;
      i_err   <= 1'b0;
      d_rdata <= '0;
      d_err   <= 1'b0;
    end else begin
      if (accept_s) begin
        sel_d_r <= txn_sel_d_s;
        err_r   <= txn_err_s;
        we_r    <= txn_we_s;
        idx_r   <= txn_idx_s;
        off_r   <= txn_off_s;
        be_r    <= txn_be_s;
        wdata_r <= txn_wdata_s;
      end
      if (enter_resp_s) begin
        if (txn_sel_d_s) begin
          d_rdata <= txn_err_s ? '0 : rd_word_s;
          d_err   <= txn_err_s;
        end else begin
          i_instr <= txn_err_s ? '0 : INSTR_W'(rd_word_s >> {txn_off_s, 3'b000});
          i_err   <= txn_err_s;
        end
      end
    end
  end

  // Byte-enabled commit on entry to RESP; response above already captured the pre-write word.
  always_ff @(posedge clk) begin
    if (enter_resp_s && txn_we_s && !txn_err_s && !rst) begin
      for (int k = 0; k < BYTES; k++) begin
        if (txn_be_s[k]) mem_r[txn_idx_s][k*8 +: 8] <= txn_wdata_s[k*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_mem_subsystem.sv
// Bench for mem_subsystem: LATENCY=1 and LATENCY=4 instances checked against a word-array model.
module tb_mem_subsystem;

  logic        clk;
  logic        rst;
  logic        i_req_valid [2];
  logic        i_req_ready [2];
  logic [63:0] i_addr [2];
  logic        i_resp_valid [2];
  logic        i_resp_ready [2];
  logic [31:0] i_instr [2];
  logic        i_err [2];
  logic        d_req_valid [2];
  logic        d_req_ready [2];
  logic [63:0] d_addr [2];
  logic        d_we [2];
  logic [7:0]  d_be [2];
  logic [63:0] d_wdata [2];
  logic        d_resp_valid [2];
  logic        d_resp_ready [2];
  logic [63:0] d_rdata [2];
  logic        d_err [2];

  logic [63:0] model [2][1024];
  logic [63:0] prev_d [2];
  logic [31:0] prev_i [2];
  logic        prev_de [2];
  logic        prev_ie [2];
  logic [63:0] got;
  int          checks;
  int          errors;

  mem_subsystem #(.LATENCY(1)) u_lat1 (
    .clk(clk), .rst(rst),
    .i_req_valid(i_req_valid[0]), .i_req_ready(i_req_ready[0]), .i_addr(i_addr[0]),
    .i_resp_valid(i_resp_valid[0]), .i_resp_ready(i_resp_ready[0]), .i_instr(i_instr[0]), .i_err(i_err[0]),
    .d_req_valid(d_req_valid[0]), .d_req_ready(d_req_ready[0]), .d_addr(d_addr[0]), .d_we(d_we[0]),
    .d_be(d_be[0]), .d_wdata(d_wdata[0]), .d_resp_valid(d_resp_valid[0]), .d_resp_ready(d_resp_ready[0]),
    .d_rdata(d_rdata[0]), .d_err(d_err[0])
  );

  mem_subsystem #(.LATENCY(4)) u_lat4 (
    .clk(clk), .rst(rst),
    .i_req_valid(i_req_valid[1]), .i_req_ready(i_req_ready[1]), .i_addr(i_addr[1]),
    .i_resp_valid(i_resp_valid[1]), .i_resp_ready(i_resp_ready[1]), .i_instr(i_instr[1]), .i_err(i_err[1]),
    .d_req_valid(d_req_valid[1]), .d_req_ready(d_req_ready[1]), .d_addr(d_addr[1]), .d_we(d_we[1]),
    .d_be(d_be[1]), .d_wdata(d_wdata[1]), .d_resp_valid(d_resp_valid[1]), .d_resp_ready(d_resp_ready[1]),
    .d_rdata(d_rdata[1]), .d_err(d_err[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, required finish before time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_prev();
    for (int u = 0; u < 2; u++) begin
      prev_d[u]  = 64'd0;
      prev_i[u]  = 32'd0;
      prev_de[u] = 1'b0;
      prev_ie[u] = 1'b0;
    end
  endtask

  // Reset with both ports requesting: nothing may be granted, all outputs must read zero.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int u = 0; u < 2; u++) begin
      i_req_valid[u] = 1'b1;
      d_req_valid[u] = 1'b1;
    end
    #1;
    for (int u = 0; u < 2; u++) begin
      chk("rst_i_ready", 64'(i_req_ready[u]), 64'd0);
      chk("rst_d_ready", 64'(d_req_ready[u]), 64'd0);
      chk("rst_i_rv", 64'(i_resp_valid[u]), 64'd0);
      chk("rst_d_rv", 64'(d_resp_valid[u]), 64'd0);
      chk("rst_instr", 64'(i_instr[u]), 64'd0);
      chk("rst_rdata", d_rdata[u], 64'd0);
      chk("rst_errs", 64'({i_err[u], d_err[u]}), 64'd0);
      i_req_valid[u] = 1'b0;
      d_req_valid[u] = 1'b0;
    end
    @(negedge clk);
    rst = 1'b0;
    clear_prev();
  endtask

  // One complete transaction on instance u, compared against the model.
  task automatic txn(input int u, input bit is_d, input logic [63:0] addr, input bit we,
                     input logic [7:0] be, input logic [63:0] wdata, input int hold,
                     input bit check, output logic [63:0] obs_v);
    int          lat;
    int          k;
    int          idx;
    bit          exp_err;
    logic [63:0] word;
    logic [63:0] mask;
    logic [63:0] exp_v;
    lat     = (u == 0) ? 1 : 4;
    exp_err = (addr >= 64'd8192) || (is_d ? (addr % 64'd8 != 64'd0) : (addr % 64'd4 != 64'd0));
    idx     = int'(addr[12:3]);
    word    = 64'd0;
    exp_v   = 64'd0;
    if (!exp_err) begin
      word = model[u][idx];
      if (is_d) exp_v = word;
      else      exp_v = (word >> ((addr % 64'd8) * 64'd8)) & 64'hFFFF_FFFF;
      if (is_d && we) begin
        mask = 64'd0;
        for (int b = 0; b < 8; b++) if (be[b]) mask = mask | (64'hFF << (8 * b));
        model[u][idx] = (word & ~mask) | (wdata & mask);
      end
    end
    @(negedge clk);
    if (is_d) begin
      d_req_valid[u] = 1'b1; d_addr[u] = addr; d_we[u] = we; d_be[u] = be; d_wdata[u] = wdata;
    end else begin
      i_req_valid[u] = 1'b1; i_addr[u] = addr;
    end
    #1;
    k = 0;
    while (!(is_d ? d_req_ready[u] : i_req_ready[u]) && k < 20) begin
      @(negedge clk); #1; k++;
    end
    if (k >= 20) begin
      checks++; errors++;
      $error("FAIL accept_timeout: observed no ready in %0d cycles, required ready", k);
      i_req_valid[u] = 1'b0; d_req_valid[u] = 1'b0; obs_v = 64'd0;
      return;
    end
    @(negedge clk);
    i_req_valid[u] = 1'b0;
    d_req_valid[u] = 1'b0;
    #1;
    k = 1;
    while (!(is_d ? d_resp_valid[u] : i_resp_valid[u]) && k < 20) begin
      @(negedge clk); #1; k++;
    end
    obs_v = is_d ? d_rdata[u] : 64'(i_instr[u]);
    if (check) begin
      chk("latency", 64'(k), 64'(lat));
      chk(is_d ? "d_rdata" : "i_instr", obs_v, exp_v);
      chk("err", 64'(is_d ? d_err[u] : i_err[u]), 64'(exp_err));
      chk("other_rv", 64'(is_d ? i_resp_valid[u] : d_resp_valid[u]), 64'd0);
      if (is_d) chk("other_data", {31'd0, i_err[u], i_instr[u]}, {31'd0, prev_ie[u], prev_i[u]});
      else      chk("other_data", d_rdata[u] ^ 64'(d_err[u]), prev_d[u] ^ 64'(prev_de[u]));
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk); #1;
      if (check) begin
        chk("hold_rv", 64'(is_d ? d_resp_valid[u] : i_resp_valid[u]), 64'd1);
        chk("hold_data", is_d ? d_rdata[u] : 64'(i_instr[u]), exp_v);
        chk("hold_ready", 64'(d_req_ready[u] | i_req_ready[u]), 64'd0);
      end
    end
    if (is_d) d_resp_ready[u] = 1'b1;
    else      i_resp_ready[u] = 1'b1;
    @(negedge clk); #1;
    if (check) chk("resp_drop", 64'(is_d ? d_resp_valid[u] : i_resp_valid[u]), 64'd0);
    d_resp_ready[u] = 1'b0;
    i_resp_ready[u] = 1'b0;
    if (is_d) begin prev_d[u] = exp_v; prev_de[u] = exp_err; end
    else      begin prev_i[u] = exp_v[31:0]; prev_ie[u] = exp_err; end
  endtask

  initial begin
    int          n;
    int          grants [4];
    int          r;
    bit          is_d;
    logic [63:0] addr;
    logic [63:0] old5;
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    for (int u = 0; u < 2; u++) begin
      i_req_valid[u] = 1'b0; i_addr[u] = 64'd0; i_resp_ready[u] = 1'b0;
      d_req_valid[u] = 1'b0; d_addr[u] = 64'd0; d_we[u] = 1'b0; d_be[u] = 8'd0;
      d_wdata[u] = 64'd0; d_resp_ready[u] = 1'b0;
    end
    clear_prev();
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Give every touched word a known value before checking anything.
    for (int u = 0; u < 2; u++)
      for (int w = 0; w < 16; w++)
        txn(u, 1'b1, 64'(w * 8), 1'b1, 8'hFF, {$urandom, $urandom}, 0, 1'b0, got);
    do_reset();

    txn(0, 1'b1, 64'h10, 1'b1, 8'hFF, 64'h1122334455667788, 0, 1'b1, got);
    txn(0, 1'b1, 64'h10, 1'b0, 8'h00, 64'd0, 0, 1'b1, got);
    chk("wr_rd_0x10", got, 64'h1122334455667788);

    txn(0, 1'b1, 64'h0, 1'b1, 8'hFF, 64'd0, 0, 1'b1, got);
    txn(0, 1'b1, 64'h0, 1'b1, 8'h0F, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1'b1, got);
    txn(0, 1'b1, 64'h0, 1'b0, 8'h00, 64'd0, 0, 1'b1, got);
    chk("be_0F", got, 64'h0000_0000_FFFF_FFFF);

    txn(0, 1'b1, 64'h3, 1'b1, 8'hFF, 64'hDEAD_BEEF_DEAD_BEEF, 0, 1'b1, got);
    chk("misalign_rdata", got, 64'd0);
    txn(0, 1'b1, 64'd8192, 1'b1, 8'hFF, 64'hDEAD_BEEF_DEAD_BEEF, 0, 1'b1, got);
    chk("range_rdata", got, 64'd0);
    txn(0, 1'b1, 64'h0, 1'b0, 8'h00, 64'd0, 0, 1'b1, got);
    chk("err_no_write", got, 64'h0000_0000_FFFF_FFFF);

    txn(1, 1'b1, 64'h18, 1'b0, 8'h00, 64'd0, 3, 1'b1, got);
    txn(1, 1'b0, 64'h1C, 1'b0, 8'h00, 64'd0, 3, 1'b1, got);
    txn(1, 1'b1, 64'h20, 1'b1, 8'hA5, {$urandom, $urandom}, 3, 1'b1, got);

    for (int u = 0; u < 2; u++) begin
      for (int t = 0; t < 40; t++) begin
        r    = int'($urandom_range(0, 9));
        is_d = 1'($urandom_range(0, 1));
        addr = 64'($urandom_range(0, 15)) * 64'd8;
        if (!is_d) addr = addr + 64'($urandom_range(0, 1)) * 64'd4;
        if (r == 0)      addr = addr + 64'($urandom_range(1, 3));
        else if (r == 1) addr = 64'd8192 + 64'($urandom_range(0, 7)) * 64'd8;
        txn(u, is_d, addr, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
            {$urandom, $urandom}, int'($urandom_range(0, 2)), 1'b1, got);
      end
    end

    // Both ports request continuously after reset: data wins the first tie, then alternation.
    do_reset();
    for (int i = 0; i < 4; i++) grants[i] = -1;
    n = 0;
    @(negedge clk);
    d_req_valid[0] = 1'b1; d_addr[0] = 64'h10; d_we[0] = 1'b0;
    i_req_valid[0] = 1'b1; i_addr[0] = 64'h14;
    d_resp_ready[0] = 1'b1; i_resp_ready[0] = 1'b1;
    for (int c = 0; c < 40 && n < 4; c++) begin
      #1;
      if (d_req_ready[0] && i_req_ready[0]) chk("rr_both_ready", 64'd1, 64'd0);
      if (d_req_ready[0]) begin grants[n] = 1; n++; end
      else if (i_req_ready[0]) begin grants[n] = 0; n++; end
      if (d_resp_valid[0]) chk("rr_d_rdata", d_rdata[0], model[0][2]);
      if (i_resp_valid[0]) chk("rr_i_instr", 64'(i_instr[0]), 64'(model[0][2][63:32]));
      @(negedge clk);
    end
    d_req_valid[0] = 1'b0;
    i_req_valid[0] = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rr_last_instr", 64'(i_instr[0]), 64'(model[0][2][63:32]));
    d_resp_ready[0] = 1'b0;
    i_resp_ready[0] = 1'b0;
    chk("rr_count", 64'(n), 64'd4);
    for (int i = 0; i < 4; i++) chk("rr_grant", 64'(grants[i]), (i % 2 == 0) ? 64'd1 : 64'd0);
    prev_d[0] = model[0][2];
    prev_i[0] = model[0][2][63:32];

    // Reset during WAIT of a write: response vanishes and the write never lands.
    old5 = model[1][5];
    @(negedge clk);
    d_req_valid[1] = 1'b1; d_addr[1] = 64'h28; d_we[1] = 1'b1; d_be[1] = 8'hFF;
    d_wdata[1] = ~old5;
    #1;
    chk("rstw_ready", 64'(d_req_ready[1]), 64'd1);
    @(negedge clk);
    d_req_valid[1] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rstw_rv", 64'(d_resp_valid[1]), 64'd0);
    chk("rstw_ready_low", 64'(d_req_ready[1]), 64'd0);
    chk("rstw_rdata", d_rdata[1], 64'd0);
    chk("rstw_instr", 64'(i_instr[1]), 64'd0);
    chk("rstw_errs", 64'({d_err[1], i_err[1]}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    clear_prev();
    txn(1, 1'b1, 64'h28, 1'b0, 8'h00, 64'd0, 0, 1'b1, got);
    chk("rstw_old_value", got, old5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
